// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the handshake and memory-bus signals of mem_port_arbiter:
//   the instruction-fetch requester (IF), the load/store requester (D) and
//   the single-ported memory (Memoria) side.
//
// Parameters:
//   ADDR_W  word-address width
//   DATA_W  data word width
//
// Signal summary:
//   if_req/if_addr                  IF request, held until if_ack
//   if_ack/if_rdata/if_err          IF completion pulse, read data, range error
//   d_req/d_rw/d_addr/d_wdata       D request (rw: 1=write), held until d_ack
//   d_ack/d_rdata/d_err             D completion pulse, load data, range error
//   mem_en/mem_rw/mem_addr/mem_wdata  memory command lines
//   mem_rdata                       memory read data (registered in memory)
//   busy                            arbiter is mid-transaction
//
// Modports:
//   slave   the arbiter's view
//   master  the view of the pipeline + memory environment driving the arbiter
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_rw, d_addr, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, if_err,
        output d_ack, d_rdata, d_err,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_rw, d_addr, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, if_err,
        input  d_ack, d_rdata, d_err,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported memory between the instruction-fetch requester
//   (IF) and the load/store requester (D). One access at a time walks
//   IDLE -> ISSUE -> WAIT -> DONE (one cycle each). D has fixed priority.
//   Addresses >= MEM_DEPTH are not sent to memory; the access still completes
//   with err=1 and read data 0.
//
// Parameters:
//   ADDR_W      word-address width (must match the interface instance)
//   DATA_W      data width (must match the interface instance)
//   MEM_DEPTH   number of memory words
//   STARVE_MAX  consecutive D grants tolerated while IF waits (guard build)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: IF/D handshakes and memory lines
//
// Build option:
//   ARB_STARVE_GUARD_EN  when defined, a counter of D grants given while
//                        if_req is high forces an IF grant once it reaches
//                        STARVE_MAX. When undefined, strict D priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int              AW1       = ADDR_W + 1;
    // One extra bit so the depth compare works even when MEM_DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_LIM = AW1'(MEM_DEPTH);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be at least 1");
    end
    if (MEM_DEPTH < 1) begin : g_bad_mem_depth
        $error("mem_port_arbiter: MEM_DEPTH must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    owner_t            r_owner;
    logic              r_rw;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_idle;
    logic              w_force_if;
    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_d_oor;
    logic              w_if_oor;

    assign w_idle   = (r_state == S_IDLE);
    assign w_d_oor  = ({1'b0, bus.d_addr}  >= DEPTH_LIM);
    assign w_if_oor = ({1'b0, bus.if_addr} >= DEPTH_LIM);

    // -----------------------------------------------------------------------
    // Starvation guard
    // -----------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
    localparam int             CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;

    // Counts D grants handed out while IF is waiting. An IF grant, or an idle
    // cycle with no IF request, means IF is not being starved: start over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_idle && !bus.if_req) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && bus.if_req) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_if = bus.if_req && (r_starve_cnt == STARVE_LIM);
`else
    assign w_force_if = 1'b0;
`endif

    // Requests are only looked at in IDLE; D wins unless the guard forces IF.
    assign w_grant_d  = w_idle && bus.d_req && !w_force_if;
    assign w_grant_if = w_idle && bus.if_req && !w_grant_d;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs. Everything is decoded from the state
    // register, so an asynchronous reset drops mem_en without a clock edge.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        bus.mem_en    = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_ack    = 1'b0;
        bus.if_err    = 1'b0;
        bus.d_ack     = 1'b0;
        bus.d_err     = 1'b0;
        bus.busy      = 1'b1;

        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (w_grant_d || w_grant_if) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
                // Out-of-range accesses never reach the memory.
                if (!r_err) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_rw    = r_rw;
                    bus.mem_addr  = r_addr;
                    bus.mem_wdata = r_wdata;
                end
            end
            S_WAIT: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                if (r_owner == OWN_D) begin
                    bus.d_ack = 1'b1;
                    bus.d_err = r_err;
                end else begin
                    bus.if_ack = 1'b1;
                    bus.if_err = r_err;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Transaction latch and read-data capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_IF;
            r_rw       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner <= OWN_D;
                r_rw    <= bus.d_rw;
                r_err   <= w_d_oor;
                r_addr  <= bus.d_addr;
                // Write data only carries meaning for a store.
                r_wdata <= bus.d_rw ? bus.d_wdata : '0;
            end else if (w_grant_if) begin
                // Fetches are always reads with no write data.
                r_owner <= OWN_IF;
                r_rw    <= 1'b0;
                r_err   <= w_if_oor;
                r_addr  <= bus.if_addr;
                r_wdata <= '0;
            end

            // mem_rdata is valid during WAIT. Errored reads return 0; stores
            // (in or out of range) never touch the load-data register.
            if (r_state == S_WAIT) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= r_err ? '0 : bus.mem_rdata;
                end else if (!r_rw) begin
                    r_d_rdata  <= r_err ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized bench for mem_port_arbiter. A behavioural memory
// stands in for Memoria; a separate reference array tracks what every word
// should hold, and the expected handshake timing follows the access rules
// (mem_en one cycle after the request edge, ack two cycles after that).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DEPTH = 1024;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (DEPTH),
        .STARVE_MAX(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of a word that has never been written.
    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 5) return 32'hDEADBEEF;
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural Memoria: registered read, data valid the cycle after mem_en.
    logic [31:0] mem_array   [0:DEPTH-1];
    bit          mem_written [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_rw) begin
                mem_array[bus.mem_addr[9:0]]   <= bus.mem_wdata;
                mem_written[bus.mem_addr[9:0]] <= 1'b1;
            end else begin
                bus.mem_rdata <= mem_written[bus.mem_addr[9:0]] ?
                                 mem_array[bus.mem_addr[9:0]] :
                                 init_word(32'(bus.mem_addr[9:0]));
            end
        end
    end

    // Reference state
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] ref_d_rdata;
    logic [31:0] ref_if_rdata;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/mem_en"},    32'(bus.mem_en),    32'h0);
        check({tag, "/mem_rw"},    32'(bus.mem_rw),    32'h0);
        check({tag, "/mem_addr"},  bus.mem_addr,       32'h0);
        check({tag, "/mem_wdata"}, bus.mem_wdata,      32'h0);
        check({tag, "/acks"},      32'({bus.d_ack, bus.if_ack}), 32'h0);
        check({tag, "/errs"},      32'({bus.d_err, bus.if_err}), 32'h0);
        check({tag, "/d_rdata"},   bus.d_rdata,        32'h0);
        check({tag, "/if_rdata"},  bus.if_rdata,       32'h0);
        check({tag, "/busy"},      32'(bus.busy),      32'h0);
    endtask

    // One isolated access, started at a falling edge with the arbiter idle.
    task automatic run_single(input string tag, input bit is_d, input bit rw,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bit in_range;
        in_range = (addr < DEPTH);
        check({tag, "/idle_before"}, 32'(bus.busy), 32'h0);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_rw = rw; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(negedge clk);                                  // cycle N+1
        check({tag, "/issue_en"}, 32'(bus.mem_en), 32'(in_range));
        check({tag, "/issue_busy"}, 32'(bus.busy), 32'h1);
        if (in_range) begin
            check({tag, "/issue_addr"}, bus.mem_addr, addr);
            check({tag, "/issue_rw"}, 32'(bus.mem_rw), 32'(is_d && rw));
            if (!is_d || rw)
                check({tag, "/issue_wdata"}, bus.mem_wdata, is_d ? wdata : 32'h0);
        end
        @(negedge clk);                                  // cycle N+2
        check({tag, "/wait_en"}, 32'(bus.mem_en), 32'h0);
        check({tag, "/wait_acks"}, 32'({bus.d_ack, bus.if_ack}), 32'h0);
        @(negedge clk);                                  // cycle N+3
        if (is_d) begin
            if (rw) begin
                if (in_range) ref_mem[addr[9:0]] = wdata;
            end else begin
                ref_d_rdata = in_range ? ref_mem[addr[9:0]] : 32'h0;
            end
        end else begin
            ref_if_rdata = in_range ? ref_mem[addr[9:0]] : 32'h0;
        end
        check({tag, "/acks"}, 32'({bus.d_ack, bus.if_ack}), is_d ? 32'h2 : 32'h1);
        check({tag, "/errs"}, 32'({bus.d_err, bus.if_err}),
              in_range ? 32'h0 : (is_d ? 32'h2 : 32'h1));
        check({tag, "/d_rdata"},  bus.d_rdata,  ref_d_rdata);
        check({tag, "/if_rdata"}, bus.if_rdata, ref_if_rdata);
        check({tag, "/done_en"}, 32'(bus.mem_en), 32'h0);
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);                                  // back in IDLE
        check({tag, "/after_acks"}, 32'({bus.d_ack, bus.if_ack}), 32'h0);
        check({tag, "/held_d"},  bus.d_rdata,  ref_d_rdata);
        check({tag, "/held_if"}, bus.if_rdata, ref_if_rdata);
    endtask

    logic [11:0] en_tr, dack_tr, iack_tr;
    logic [31:0] addr_at [0:11];
    int          d_before, wait_cnt, ack_cnt;
    bit          if_seen;
    bit          r_is_d, r_rw;
    logic [31:0] r_addr, r_wdata;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(32'(i));
        ref_d_rdata  = '0;
        ref_if_rdata = '0;
        rst_n       = 1'b0;
        bus.if_req  = 1'b0; bus.if_addr = '0;
        bus.d_req   = 1'b0; bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // IF read of the preloaded word
        run_single("if_read5", 1'b0, 1'b0, 32'd5, 32'h0);
        check("if_read5/value", bus.if_rdata, 32'hDEADBEEF);

        // D write then read back
        run_single("d_write10", 1'b1, 1'b1, 32'd10, 32'h0000_1234);
        run_single("d_read10",  1'b1, 1'b0, 32'd10, 32'h0);
        check("d_read10/value", bus.d_rdata, 32'h0000_1234);

        // Range errors: first out-of-range word, and the last valid word
        run_single("d_oor1024", 1'b1, 1'b0, 32'd1024, 32'h0);
        run_single("if_last",   1'b0, 1'b0, 32'd1023, 32'h0);
        run_single("if_oor",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);

        // Contention: both requests rise together
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'd7;
        bus.if_req = 1'b1; bus.if_addr = 32'd8;
        en_tr = '0; dack_tr = '0; iack_tr = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            en_tr[k]   = bus.mem_en;
            dack_tr[k] = bus.d_ack;
            iack_tr[k] = bus.if_ack;
            addr_at[k] = bus.mem_addr;
            if (bus.d_ack) begin
                check("cont/d_rdata", bus.d_rdata, ref_mem[7]);
                bus.d_req = 1'b0;
            end
            if (bus.if_ack) begin
                check("cont/if_rdata", bus.if_rdata, ref_mem[8]);
                bus.if_req = 1'b0;
            end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("cont/en_trace",   32'(en_tr),   32'h022);
        check("cont/dack_trace", 32'(dack_tr), 32'h008);
        check("cont/iack_trace", 32'(iack_tr), 32'h080);
        check("cont/d_addr",  addr_at[1], 32'd7);
        check("cont/if_addr", addr_at[5], 32'd8);
        check("cont/ack_total", 32'($countones(dack_tr) + $countones(iack_tr)), 32'd2);
        ref_d_rdata  = ref_mem[7];
        ref_if_rdata = ref_mem[8];
        check("cont/idle", 32'(bus.busy), 32'h0);

        // Starvation: IF held, D continuously requesting
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'd20;
        bus.if_req = 1'b1; bus.if_addr = 32'd30;
        d_before = 0; if_seen = 1'b0;
        for (int k = 0; k < 40 && !if_seen; k++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (bus.mem_addr == 32'd30) if_seen = 1'b1;
                else d_before++;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve/if_granted", 32'(if_seen), 32'h1);
        check("starve/d_grants",   32'(d_before), 32'd4);
`else
        check("starve/if_granted", 32'(if_seen), 32'h0);
        check("starve/d_grants",   32'(d_before), 32'd10);
`endif
        wait_cnt = 0;
        while (!(bus.d_ack || bus.if_ack) && wait_cnt < 8) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("starve/ack_seen", 32'(bus.d_ack || bus.if_ack), 32'h1);
        ref_d_rdata = ref_mem[20];
`ifdef ARB_STARVE_GUARD_EN
        ref_if_rdata = ref_mem[30];
        check("starve/ack_owner", 32'({bus.d_ack, bus.if_ack}), 32'h1);
        check("starve/if_rdata", bus.if_rdata, ref_if_rdata);
`else
        check("starve/ack_owner", 32'({bus.d_ack, bus.if_ack}), 32'h2);
`endif
        check("starve/d_rdata", bus.d_rdata, ref_d_rdata);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        @(negedge clk);
        check("starve/idle", 32'(bus.busy), 32'h0);

        // Randomized isolated accesses against the reference memory
        for (int n = 0; n < 40; n++) begin
            r_is_d  = 1'($urandom_range(0, 1));
            r_rw    = r_is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            r_wdata = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                r_addr = 32'd1024 + $urandom_range(0, 5000);
                r_rw   = 1'b0;
            end else begin
                r_addr = $urandom_range(0, 63);
            end
            run_single($sformatf("rand%0d", n), r_is_d, r_rw, r_addr, r_wdata);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset during ISSUE
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'd3;
        @(negedge clk);
        check("midrst/issue_en", 32'(bus.mem_en), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_d_rdata = '0; ref_if_rdata = '0;
        ack_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.d_ack || bus.if_ack) ack_cnt++;
        end
        check("midrst/no_ack", 32'(ack_cnt), 32'h0);

        // Arbiter works again after the abandoned access
        run_single("postrst", 1'b1, 1'b0, 32'd3, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
